// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - RV32I field encoder with FIFO-buffered instruction-memory loader (optional ENC_LEGAL_CHECK_EN)
module instr_encode_loader #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [4:0]        op_code,
    input  logic [3:0]        sub_op_code,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] instr_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [PW:0]       r_wptr;
    logic [PW:0]       r_rptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;

    logic [31:0] w_instr;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_legal;
    logic        w_empty;
    logic        w_full;
    logic        w_active;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    assign w_f3 = sub_op_code[2:0];
    assign w_f7 = {1'b0, sub_op_code[3], 5'b00000};

    // Unknown op_codes fall back to the I-type layout.
    always_comb begin
        w_instr = {imm[11:0], rs1, w_f3, rd, op_code, 2'b11};
        case (op_code)
            5'b01100: w_instr = {w_f7, rs2, rs1, w_f3, rd, op_code, 2'b11};
            5'b00100: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_instr = {w_f7, imm[4:0], rs1, w_f3, rd, op_code, 2'b11};
            end
            5'b01000: w_instr = {imm[11:5], rs2, rs1, w_f3, imm[4:0], op_code, 2'b11};
            5'b11000: w_instr = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11],
                                 op_code, 2'b11};
            5'b01101, 5'b00101: w_instr = {imm[31:12], rd, op_code, 2'b11};
            5'b11011: w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_code, 2'b11};
            default: ;
        endcase
    end

`ifdef ENC_LEGAL_CHECK_EN
    always_comb begin
        w_legal = 1'b0;
        case (op_code)
            5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
            5'b11011, 5'b11001, 5'b01101, 5'b00101: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end
`else
    assign w_legal = 1'b1;
`endif

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign req_ready = (r_state == S_RUN) && !w_full;
    assign w_accept = req_valid && req_ready;
    assign w_push   = w_accept && w_legal;
    assign mem_we   = w_active && !w_empty;
    assign w_pop    = mem_we && mem_ready;

    assign mem_wdata   = mem_we ? r_fifo[r_rptr[PW-1:0]] : 32'd0;
    assign mem_addr    = r_addr;
    assign instr_count = r_count;
    assign busy        = w_active;
    assign done        = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr[PW-1:0]] <= w_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr & ~ADDR_W'(3);
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN:   if (w_accept && req_last) r_state <= S_DRAIN;
                S_DRAIN: if (w_empty) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) begin
                r_rptr  <= r_rptr + PTR_ONE;
                r_addr  <= r_addr + ADDR_W'(4);
                r_count <= r_count + ADDR_W'(1);
            end
        end
    end

`ifdef ENC_LEGAL_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_err <= 1'b0;
        else if (w_accept && !w_legal)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - randomized bench with behavioural loader model for instr_encode_loader
module tb_instr_encode_loader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_last = 1'b0;
    logic [4:0]  op_code = '0;
    logic [3:0]  sub_op_code = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        mem_ready = 1'b0;

    logic        req_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata, instr_count;
    logic        req_ready8, mem_we8, busy8, done8, err8;
    logic [7:0]  mem_addr8, instr_count8;
    logic [31:0] mem_wdata8;

    int n_chk = 0;
    int n_err = 0;
    int mr_mode = 0;

    logic [31:0] wa[$], wd[$];
    logic [7:0]  wa8[$];

    int          m_phase;
    logic [31:0] m_q[$];
    logic [31:0] m_addr, m_count;
    bit          m_err;

    instr_encode_loader #(.ADDR_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .op_code(op_code), .sub_op_code(sub_op_code), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err), .instr_count(instr_count));

    instr_encode_loader #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[7:0]),
        .req_valid(req_valid), .req_ready(req_ready8), .req_last(req_last),
        .op_code(op_code), .sub_op_code(sub_op_code), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_ready(mem_ready),
        .busy(busy8), .done(done8), .err(err8), .instr_count(instr_count8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] sub,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] lo, f3, b30, regs_rs, i12;
        lo  = {25'd0, op, 2'b11} | (32'(d) << 7);
        f3  = 32'(sub[2:0]) << 12;
        b30 = 32'(sub[3]) << 30;
        regs_rs = (32'(s2) << 20) | (32'(s1) << 15);
        i12 = (im & 32'hFFF) << 20;
        case (op)
            5'b01100: return b30 | regs_rs | f3 | lo;
            5'b00100: begin
                if (sub[2:0] == 3'd1 || sub[2:0] == 3'd5)
                    return b30 | ((im & 32'h1F) << 20) | (32'(s1) << 15) | f3 | lo;
                return i12 | (32'(s1) << 15) | f3 | lo;
            end
            5'b01000: return (((im >> 5) & 32'h7F) << 25) | regs_rs | f3 | ((im & 32'h1F) << 7)
                             | {25'd0, op, 2'b11};
            5'b11000: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs_rs | f3
                             | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7)
                             | {25'd0, op, 2'b11};
            5'b01101, 5'b00101: return (im & 32'hFFFFF000) | lo;
            5'b11011: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                             | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | lo;
            default: return i12 | (32'(s1) << 15) | f3 | lo;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
`ifdef ENC_LEGAL_CHECK_EN
        return op inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                          5'b11011, 5'b11001, 5'b01101, 5'b00101};
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: a queue of pending words plus session phase (0 idle, 1 loading, 2 draining, 3 finishing).
    always @(negedge clk) begin
        bit          e_we, e_rdy, wr_ok, acc;
        logic [31:0] e_wd;
        if (!rst_n) begin
            m_phase = 0; m_q.delete(); m_addr = 0; m_count = 0; m_err = 0;
        end
        e_we  = (m_phase == 1 || m_phase == 2) && m_q.size() != 0;
        e_wd  = e_we ? m_q[0] : 32'd0;
        e_rdy = (m_phase == 1) && m_q.size() < DEPTH;
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_addr", mem_addr, m_addr);
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("err", 32'(err), 32'(m_err));
        chk("instr_count", instr_count, m_count);
        chk("mem_we8", 32'(mem_we8), 32'(e_we));
        chk("mem_wdata8", mem_wdata8, e_wd);
        chk("mem_addr8", 32'(mem_addr8), m_addr & 32'hFF);
        chk("req_ready8", 32'(req_ready8), 32'(e_rdy));
        chk("instr_count8", 32'(instr_count8), m_count & 32'hFF);
        chk("done8", 32'(done8), 32'(m_phase == 3));
        if (rst_n) begin
            wr_ok = e_we && mem_ready;
            if (mem_we && mem_ready) begin
                wa.push_back(mem_addr); wd.push_back(mem_wdata); wa8.push_back(mem_addr8);
            end
            case (m_phase)
                0: if (start) begin
                    m_addr = base_addr & ~32'd3; m_count = 0; m_err = 0; m_phase = 1;
                end
                1: begin
                    acc = req_valid && e_rdy;
                    if (wr_ok) begin void'(m_q.pop_front()); m_addr += 4; m_count++; end
                    if (acc) begin
                        if (is_legal(op_code)) m_q.push_back(enc(op_code, sub_op_code, rd, rs1, rs2, imm));
                        else m_err = 1;
                        if (req_last) m_phase = 2;
                    end
                end
                2: begin
                    if (m_q.size() == 0) m_phase = 3;
                    else if (wr_ok) begin void'(m_q.pop_front()); m_addr += 4; m_count++; end
                end
                default: m_phase = 0;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (mr_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = 1'b0;
            endcase
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wa8.delete();
    endtask

    task automatic begin_session(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [3:0] sub, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input bit last);
        int cnt = 0;
        op_code = op; sub_op_code = sub; rd = d; rs1 = s1; rs2 = s2; imm = im;
        req_valid = 1'b1; req_last = last;
        @(negedge clk);
        while (!req_ready && cnt < 300) begin @(negedge clk); cnt++; end
        if (cnt >= 300) chk("req_accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_last = 1'b0;
    endtask

    task automatic wait_done();
        int cnt = 0;
        @(negedge clk);
        while (!done && cnt < 500) begin @(negedge clk); cnt++; end
        if (cnt >= 500) chk("done_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    logic [4:0] legal_ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                  5'b11011, 5'b11001, 5'b01101, 5'b00101};

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_w;
        int n;
        #1;
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", instr_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("enc_addi", enc(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5), 32'h00500093);
        chk("enc_sub",  enc(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0), 32'h402081B3);
        chk("enc_sw",   enc(5'b01000, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020A423);

        mr_mode = 0; clear_log();
        begin_session(32'h101);
        send(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, 0);
        send(5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        send(5'b01000, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8, 1);
        wait_done();
        chk("basic_count", instr_count, 3);
        chk("basic_nwrites", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("basic_w0", wd[0], 32'h00500093); chk("basic_a0", wa[0], 32'h100);
            chk("basic_w1", wd[1], 32'h402081B3); chk("basic_a1", wa[1], 32'h104);
            chk("basic_w2", wd[2], 32'h0020A423); chk("basic_a2", wa[2], 32'h108);
        end

        clear_log();
        begin_session(32'h400);
        send(5'b11000, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8, 0);
        send(5'b00100, 4'b1101, 5'd4, 5'd1, 5'd0, 32'd3, 0);
        send(5'b01101, 4'b0000, 5'd5, 5'd0, 5'd0, 32'h12345000, 0);
        send(5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd16, 1);
        wait_done();
        chk("fmt_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("enc_beq", wd[0], 32'h00208463);
            chk("enc_srai", wd[1], 32'h4030D213);
            chk("enc_lui", wd[2], 32'h123452B7);
            chk("enc_jal", wd[3], 32'h010000EF);
        end

        clear_log(); mr_mode = 2;
        begin_session(32'h800);
        first_w = enc(5'b00100, 4'b0000, 5'd7, 5'd3, 5'd0, 32'h7F);
        send(5'b00100, 4'b0000, 5'd7, 5'd3, 5'd0, 32'h7F, 0);
        for (int i = 0; i < 3; i++) send(legal_ops[i], 4'(i), 5'(i + 8), 5'(i), 5'(i + 1), 32'(i * 44), 0);
        op_code = 5'b01000; sub_op_code = 4'b0010; rd = 5'd0; rs1 = 5'd9; rs2 = 5'd10; imm = 32'h3C;
        req_valid = 1'b1; req_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(req_ready), 0);
            chk("bp_wdata_held", mem_wdata, first_w);
        end
        @(posedge clk); #1;
        mr_mode = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_last = 1'b0;
        wait_done();
        chk("bp_nwrites", wa.size(), 5);
        for (int i = 0; i < wa.size(); i++) chk("bp_addr", wa[i], 32'h800 + 32'(4 * i));

        clear_log();
        begin_session(32'hFFFFFFFC);
        send(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 0);
        send(5'b00100, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd2, 1);
        wait_done();
        chk("wrap_nwrites", wa8.size(), 2);
        if (wa8.size() == 2) begin
            chk("wrap8_a0", 32'(wa8[0]), 32'hFC); chk("wrap8_a1", 32'(wa8[1]), 32'h00);
            chk("wrap32_a1", wa[1], 32'h0);
        end

        clear_log(); mr_mode = 2;
        begin_session(32'h200);
        send(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd11, 0);
        send(5'b00100, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd12, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0); chk("rst_addr", mem_addr, 0);
        chk("rst_count", instr_count, 0); chk("rst_wdata", mem_wdata, 0);
        mr_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_writes", wa.size(), 0);
        begin_session(32'h300);
        send(5'b00100, 4'b0000, 5'd3, 5'd0, 5'd0, 32'd13, 0);
        send(5'b00100, 4'b0000, 5'd4, 5'd0, 5'd0, 32'd14, 1);
        wait_done();
        chk("post_rst_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin chk("post_rst_a0", wa[0], 32'h300); chk("post_rst_a1", wa[1], 32'h304); end

        clear_log();
        begin_session(32'h500);
        send(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 0);
        send(5'b11111, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd2, 0);
        send(5'b00100, 4'b0000, 5'd3, 5'd0, 5'd0, 32'd3, 1);
        wait_done();
`ifdef ENC_LEGAL_CHECK_EN
        chk("ill_err", 32'(err), 1);
        chk("ill_nwrites", wa.size(), 2);
        if (wa.size() == 2) chk("ill_consec", wa[1], 32'h504);
        chk("ill_count", instr_count, 2);
`else
        chk("ill_err", 32'(err), 0);
        chk("ill_nwrites", wa.size(), 3);
        if (wa.size() == 3) chk("ill_itype", wd[1], 32'h0020017F);
`endif
        begin_session(32'h600);
        chk("err_cleared", 32'(err), 0);
        send(5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 1);
        wait_done();

        mr_mode = 1;
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(6, 12);
            begin_session($urandom);
            for (int k = 0; k < n; k++) begin
                logic [4:0] op;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 8)];
                send(op, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, k == n - 1);
            end
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Writer-side counterpart of the core's instruction decode path.
- Accepts decoded-style fields: 5-bit op_code = instr[6:2], 4-bit sub_op_code = {instr[30], funct3}, register indices and an immediate.
- Encodes each request into an RV32I word, buffers it in a small FIFO, and streams the words into instruction memory at consecutive word addresses.
- Used as the boot/test program loader ahead of the single-cycle core.

Parameters:
- ADDR_W, 32, instruction memory byte-address width.
- FIFO_DEPTH, 4, encoded-word FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load session at base_addr; honoured only in IDLE.
- base_addr  input  ADDR_W  first write address; bits [1:0] are ignored and treated as 0.
- req_valid  input  1  encode request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_last  input  1  qualifies the final request of the session.
- op_code  input  5  instr[6:2].
- sub_op_code  input  4  {instr[30], funct3}.
- rd, rs1, rs2  input  5 each  register indices.
- imm  input  32  immediate value in the form the sign extender produces (byte offset or value; U-type uses imm[31:12]).
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse when the session completes.
- err  output  1  sticky illegal-op flag.
- instr_count  output  ADDR_W  words written this session.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; address and count 0.
- Encoding is combinational on the request. In every format, instr[1:0]=2'b11 and instr[6:2]=op_code. Format is selected from op_code:
  - 01100 R: funct7 = {0, sub[3], 00000}.
  - 00100 I-ALU: imm[11:0]. For shifts (funct3 001 or 101), instr[31:25] = {0, sub[3], 00000} and instr[24:20] = imm[4:0].
  - 00000 load and 11001 JALR: I-type with imm[11:0].
  - 01000 S: standard S-type split.
  - 11000 B: bits imm[12|10:5|4:1|11].
  - 01101 and 00101 U: imm[31:12].
  - 11011 J: bits imm[20|10:1|11|19:12].
  - Any other op_code: I-type layout.
  - Fields that a format does not use are ignored.
- State machine:
  - IDLE: on start, load the address register from base_addr, clear count and err, go to RUN.
  - RUN: req_ready = !fifo_full. An accepted request pushes its encoded word in the same cycle, so it is visible at the FIFO head the next cycle. An accepted request with req_last set moves to DRAIN.
  - DRAIN: req_ready = 0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Write side: mem_we = !fifo_empty in RUN or DRAIN. mem_wdata and mem_addr are held stable until mem_ready.
  - On each accepted write: pop the FIFO, add 4 to mem_addr (wraps modulo 2^ADDR_W), increment instr_count (wraps).
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- When the FIFO is full, req_ready is 0 even if a pop occurs in that cycle (no combinational path from mem_ready to req_ready).
- start outside IDLE is ignored.
- req_last with an illegal op_code (feature enabled) still moves to DRAIN.
- Asynchronous reset mid-session discards FIFO contents and returns to IDLE with no further writes.

Optional Feature:
- Macro: ENC_LEGAL_CHECK_EN.
- Defined: op_codes outside {01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101} are still accepted but are not pushed. err sets and holds until the next start; the address and count do not advance.
- Undefined: every op_code is encoded per the rules above and err is tied to 0.

Test Plan:
- Basic encodes: start with base_addr 0x100, then send three requests, the last with req_last, while mem_ready is held at 1.
  - addi x1,x0,5 (op 00100, sub 0000, rd 1, imm 5) -> 0x00500093 @0x100.
  - sub x3,x1,x2 (op 01100, sub 1000) -> 0x402081B3 @0x104.
  - sw x2,8(x1) (op 01000, sub 0010) -> 0x0020A423 @0x108.
  - Then done pulses once and instr_count = 3.
- Branch, shift, U and J encodes:
  - beq x1,x2,+8 -> 0x00208463.
  - srai x4,x1,3 (sub 1101) -> 0x4030D213.
  - lui x5 with imm 0x12345000 -> 0x123452B7.
  - jal x1,+16 -> 0x010000EF.
- Backpressure: hold mem_ready at 0 and send 5 requests.
  - req_ready drops after 4 accepts (FIFO_DEPTH=4) and mem_wdata stays stable.
  - Release mem_ready: words are written in order at consecutive addresses, with no loss or duplication.
- Address wrap: ADDR_W=8, base_addr 0xFC, two words -> written at 0xFC then 0x00.
- Reset mid-session: assert rst_n low while 2 words are queued.
  - All outputs go to 0 immediately and no writes occur after release.
  - A following start works normally.
- Feature (ENC_LEGAL_CHECK_EN): send op 11111 between two legal requests.
  - err goes to 1, only 2 writes occur, at consecutive addresses.
  - The next start clears err.
